// File: rtl/fetch_unit_if.sv
// fetch_unit_if: fetch front-end bus carrying imem access, redirect and the decode handshake
interface fetch_unit_if;
  logic [63:0] imem_pc;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [63:0] out_pc;
  modport master (
    output imem_pc, out_valid, out_instr, out_pc,
    input  imem_instr, redirect_valid, redirect_pc, out_ready
  );
  modport slave (
    input  imem_pc, out_valid, out_instr, out_pc,
    output imem_instr, redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: fetch PC plus {pc,instr} FIFO toward decode; define FETCH_BYPASS_EN for the empty-FIFO bypass
module fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          DEPTH    = 4
) (
  input logic          clk,
  input logic          rst,
  fetch_unit_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [63:0]   fetch_pc;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count;
  logic [63:0]   pc_mem [DEPTH];
  logic [31:0]   instr_mem [DEPTH];
  logic empty, byp, pop, push, wr, rd;
  assign empty = count == '0;
`ifdef FETCH_BYPASS_EN
  assign byp = empty & ~bus.redirect_valid;
`else
  assign byp = 1'b0;
`endif
  assign bus.out_valid = (~empty | byp) & ~bus.redirect_valid;
  assign pop  = bus.out_valid & bus.out_ready;
  assign push = ~bus.redirect_valid & (count != FULL | pop);
  // a bypassed word taken by decode the same cycle never enters the FIFO
  assign wr = push & ~(byp & bus.out_ready);
  assign rd = pop & ~empty;
  assign bus.imem_pc   = fetch_pc;
  assign bus.out_instr = ~empty ? instr_mem[rd_ptr] : byp ? bus.imem_instr : '0;
  assign bus.out_pc    = ~empty ? pc_mem[rd_ptr] : byp ? fetch_pc : '0;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      fetch_pc <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else if (bus.redirect_valid) begin
      fetch_pc <= bus.redirect_pc & ~64'h3;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      if (push) fetch_pc <= fetch_pc + 64'd4;
      if (wr) wr_ptr <= wr_ptr + AW'(1);
      if (rd) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(wr) - (AW+1)'(rd);
    end
  always_ff @(posedge clk)
    if (wr) begin
      pc_mem[wr_ptr]    <= fetch_pc;
      instr_mem[wr_ptr] <= bus.imem_instr;
    end
endmodule
